data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Data-memory responder for the MEM stage. Consumes the MemRead/MemWrite/address/store-data outputs of the EX/MEM pipeline register, services them against an internal word array with a configurable access latency, and returns load data for the MEM/WB register. While an access is in progress it raises Stall so the hazard logic can freeze the PC, IF/ID, ID/EX and EX/MEM registers.

## Interface
- DEPTH, 256: number of 32-bit words in the array; power of two.
- LAT, 2: extra wait cycles per access, 0..15; 0 selects single-cycle mode.
- AW, log2(DEPTH): word-index width, derived, not overridable.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- MemRead  input  1  load request from EX/MEM.
- MemWrite  input  1  store request from EX/MEM.
- Addr  input  32  byte address (EX/MEM ALU result).
- WriteData  input  32  store data (EX/MEM D2).
- ReadData  output  32  load data to MEM/WB.
- Stall  output  1  pipeline freeze request, combinational.
- Err  output  1  sticky: misaligned or conflicting request seen.

## Operation
- Request = MemRead | MemWrite. Both high: treated as a write, Err set.
- Word index = Addr[AW+1:2]; upper bits ignored (address wraps modulo DEPTH*4). Addr[1:0] != 0: access proceeds on truncated index, Err set.
- LAT = 0: no FSM. Read is combinational (ReadData = array[index] while MemRead, else holds last registered value is not required; drives array output). Write commits at the rising edge of the request cycle. Stall tied 0.
- LAT >= 1: FSM states IDLE, BUSY, DONE.
  - IDLE: on Request, latch index, WriteData, op into holding regs, load counter = LAT-1, go BUSY. Stall = Request (combinational).
  - BUSY: Stall = 1. Counter decrements each cycle; at counter == 0, on that edge: write commits array[idx] = data (write op) or ReadData register loads array[idx] (read op); go DONE.
  - DONE: Stall = 0; ReadData valid; pipeline advances at end of this cycle. Unconditionally return to IDLE; the request present in DONE is the already-serviced one and is never restarted.
- Inputs changing during BUSY have no effect (holding regs used).
- ReadData holds its value until the next completed read; writes do not alter it.
- Err cleared only by rst.

## Timing
- Reset values: state IDLE, counter 0, holding regs 0, ReadData 0, Err 0, Stall 0 (no request). Array contents are not reset.
- Request first seen in cycle T (LAT >= 1): Stall high T..T+LAT; commit/capture edge ends cycle T+LAT; DONE in cycle T+LAT+1 with Stall low; next request accepted no earlier than T+LAT+2. Occupancy LAT+2 cycles per access.
- Back-to-back accesses: no overlap, one idle-state cycle between DONE and next acceptance.
- rst during BUSY: access aborted; a write whose commit edge has not occurred is not performed; Err cleared.
- rst during DONE: ReadData forced to 0, stage must reissue.
- No request in IDLE: state, ReadData, Stall unchanged/0.

## Structure
- Shared package dmem_pkg: state enum (IDLE, BUSY, DONE), default LAT and DEPTH constants, counter width (4 bits).
- Sub-module data_mem_array: DEPTH x 32, synchronous write, asynchronous read, no reset. Controller holds FSM, counter, holding regs, ReadData reg, Err.

## Test plan
- Reset: assert rst mid-sim -> ReadData 0, Stall 0, Err 0, state IDLE.
- LAT=2 store then load: MemWrite Addr 0x10 data 0xDEADBEEF at T -> Stall high T..T+2, low T+3; then MemRead 0x10 -> ReadData 0xDEADBEEF in its DONE cycle.
- Wrap/alias, DEPTH=256: store 0x12345678 to 0x400, load 0x000 -> 0x12345678.
- Misaligned load Addr 0x13 -> returns word at 0x10, Err 1 and stays 1 until rst.
- Conflict: MemRead=MemWrite=1 Addr 0x20 data 0xA5A5A5A5 -> array[8]=0xA5A5A5A5, ReadData unchanged, Err 1.
- Abort: MemWrite 0x30 data 0x1, rst pulse in BUSY before commit edge -> later load of 0x30 returns prior contents; LAT=0 build: Stall never high, load data same cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package dmem_pkg;

  // Controller states: IDLE waits for a request, BUSY counts wait cycles,
  // DONE presents the result for the one cycle the pipeline advances.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DEPTH = 256;
  localparam int DEF_LAT   = 2;
  localparam int CNT_W     = 4;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// EX/MEM -> data memory request bus and MEM/WB return path.
//
// Handshake: a request (MemRead | MemWrite) is held stable by the pipeline
// for as long as Stall is high; the access is complete in the first cycle
// of the request with Stall low, and the pipeline advances at the end of
// that cycle. ReadData is valid in that cycle for loads.
interface data_mem_ctrl_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Err;

  modport master (
    output MemRead, MemWrite, Addr, WriteData,
    input  ReadData, Stall, Err
  );

  modport slave (
    input  MemRead, MemWrite, Addr, WriteData,
    output ReadData, Stall, Err
  );
endinterface

// File: rtl/data_mem_array.sv
// DEPTH x 32 word array: synchronous write, asynchronous read, no reset.
module data_mem_array #(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Store commits on the rising edge when the write enable is high.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory responder with configurable access latency.
// LAT = 0 gives a single-cycle combinational-read memory; LAT >= 1 runs a
// IDLE/BUSY/DONE sequencer that stalls the pipeline for LAT+1 cycles.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LAT   = DEF_LAT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_ctrl_if.slave  bus,
  output state_t          state_o
);

  logic          req;
  logic          bad;
  logic          accept;
  logic [AW-1:0] idx_in;
  logic          err_q, err_d;
  logic          arr_we;
  logic [AW-1:0] arr_waddr;
  logic [AW-1:0] arr_raddr;
  logic [31:0]   arr_wdata;
  logic [31:0]   arr_rdata;

  // Upper address bits are ignored so the address space wraps modulo DEPTH*4.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.Addr[31:AW+2];

  assign req    = bus.MemRead | bus.MemWrite;
  assign bad    = (bus.MemRead & bus.MemWrite) | (bus.Addr[1:0] != 2'b00);
  assign idx_in = bus.Addr[AW+1:2];

  // Err is sticky: any accepted conflicting or misaligned request sets it.
  assign err_d = err_q | (accept & bad);

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.Err = err_q;

  data_mem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .raddr_i (arr_raddr),
    .rdata_o (arr_rdata)
  );

  if (LAT == 0) begin : g_single
    // Single-cycle mode: read straight from the array, write on the
    // request edge, never stall. A conflicting request is a write.
    assign accept       = req;
    assign arr_we       = bus.MemWrite;
    assign arr_waddr    = idx_in;
    assign arr_wdata    = bus.WriteData;
    assign arr_raddr    = idx_in;
    assign bus.ReadData = arr_rdata;
    assign bus.Stall    = 1'b0;
    assign state_o      = IDLE;
  end else begin : g_multi
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             wr_q, wr_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             stall;
    logic             we;

    assign accept = (state_q == IDLE) & req;

    // State, counter, holding registers and the load-data register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        idx_q   <= '0;
        wdata_q <= '0;
        wr_q    <= 1'b0;
        rdata_q <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        wr_q    <= wr_d;
        rdata_q <= rdata_d;
      end
    end

    // Next-state, stall and commit logic; the holding registers freeze the
    // request at acceptance so later input changes are ignored.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      stall   = 1'b0;
      we      = 1'b0;
      case (state_q)
        IDLE: begin
          stall = req;
          if (req) begin
            idx_d   = idx_in;
            wdata_d = bus.WriteData;
            wr_d    = bus.MemWrite;
            cnt_d   = CNT_W'(LAT - 1);
            state_d = BUSY;
          end
        end
        BUSY: begin
          stall = 1'b1;
          if (cnt_q == '0) begin
            if (wr_q) we      = 1'b1;
            else      rdata_d = arr_rdata;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          // The request still present here is the one just serviced.
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    assign arr_we       = we;
    assign arr_waddr    = idx_q;
    assign arr_wdata    = wdata_q;
    assign arr_raddr    = idx_q;
    assign bus.ReadData = rdata_q;
    assign bus.Stall    = stall;
    assign state_o      = state_q;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a LAT=2 instance carries the main
// sequence, a LAT=0 instance covers single-cycle mode.
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  localparam int LAT_A = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_ctrl_if ia ();
  data_mem_ctrl_if iz ();
  state_t state_a;
  state_t state_z;

  data_mem_ctrl #(.DEPTH(256), .LAT(LAT_A)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .bus     (ia.slave),
    .state_o (state_a)
  );

  data_mem_ctrl #(.DEPTH(256), .LAT(0)) dut_z (
    .clk     (clk),
    .rst     (rst),
    .bus     (iz.slave),
    .state_o (state_z)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input state_t obs, input state_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drop_a();
    ia.MemRead   = 1'b0;
    ia.MemWrite  = 1'b0;
    ia.Addr      = 32'h0;
    ia.WriteData = 32'h0;
  endtask

  // One full LAT_A access. Inputs are scrambled during BUSY/DONE to show
  // the holding registers are used. With chk_rd, ReadData in the DONE
  // cycle is compared against the head of exp_q.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input bit chk_rd);
    logic [31:0] exp;
    @(negedge clk);
    ia.MemRead = rd; ia.MemWrite = wr; ia.Addr = addr; ia.WriteData = wd;
    #1 chk_b("stall_req", ia.Stall, 1'b1);
    for (int i = 0; i < LAT_A; i++) begin
      @(negedge clk);
      ia.Addr = addr ^ 32'h4; ia.WriteData = ~wd;
      #1 chk_b("stall_busy", ia.Stall, 1'b1);
      chk_s("state_busy", state_a, BUSY);
    end
    @(negedge clk);
    #1 chk_b("stall_done", ia.Stall, 1'b0);
    chk_s("state_done", state_a, DONE);
    if (chk_rd) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $error("FAIL rdata_queue observed empty expected entry");
      end else begin
        exp = exp_q.pop_front();
        chk_w("rdata_done", ia.ReadData, exp);
      end
    end
    @(negedge clk);
    drop_a();
    #1 chk_s("state_idle", state_a, IDLE);
    chk_b("stall_idle", ia.Stall, 1'b0);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    drop_a();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    drop_a();
    iz.MemRead = 1'b0; iz.MemWrite = 1'b0; iz.Addr = 32'h0; iz.WriteData = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_w("rst_rdata", ia.ReadData, 32'h0);
    chk_b("rst_stall", ia.Stall, 1'b0);
    chk_b("rst_err", ia.Err, 1'b0);
    chk_s("rst_state", state_a, IDLE);
    chk_b("rst_stall_z", iz.Stall, 1'b0);
    chk_b("rst_err_z", iz.Err, 1'b0);

    // Stores leave ReadData untouched.
    exp_q.push_back(32'h0);
    access(1'b0, 1'b1, 32'h14, 32'h1111_1111, 1'b1);
    exp_q.push_back(32'h0);
    access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1);

    // Loads; scrambled BUSY address must not redirect them.
    exp_q.push_back(32'h1111_1111);
    access(1'b1, 1'b0, 32'h14, 32'h0, 1'b1);
    exp_q.push_back(32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);

    // Address wrap: 0x400 aliases 0x000.
    exp_q.push_back(32'hDEAD_BEEF);
    access(1'b0, 1'b1, 32'h400, 32'h1234_5678, 1'b1);
    exp_q.push_back(32'h1234_5678);
    access(1'b1, 1'b0, 32'h000, 32'h0, 1'b1);
    chk_b("err_clean", ia.Err, 1'b0);

    // Misaligned load reads the truncated word and sets Err.
    exp_q.push_back(32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'h13, 32'h0, 1'b1);
    chk_b("err_misalign", ia.Err, 1'b1);

    pulse_rst();
    chk_b("rst2_err", ia.Err, 1'b0);
    chk_w("rst2_rdata", ia.ReadData, 32'h0);
    chk_s("rst2_state", state_a, IDLE);
    chk_b("rst2_stall", ia.Stall, 1'b0);

    // Conflict: treated as a write, ReadData unchanged, Err set.
    exp_q.push_back(32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    exp_q.push_back(32'hDEAD_BEEF);
    access(1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5, 1'b1);
    chk_b("err_conflict", ia.Err, 1'b1);
    exp_q.push_back(32'hA5A5_A5A5);
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);

    // No request: everything holds.
    repeat (3) begin
      @(negedge clk);
      #1 chk_s("hold_state", state_a, IDLE);
      chk_w("hold_rdata", ia.ReadData, 32'hA5A5_A5A5);
      chk_b("hold_stall", ia.Stall, 1'b0);
    end
    chk_b("err_sticky", ia.Err, 1'b1);

    // Abort: reset in BUSY before the commit edge drops the store.
    exp_q.push_back(32'hA5A5_A5A5);
    access(1'b0, 1'b1, 32'h30, 32'hCAFE_0030, 1'b1);
    @(negedge clk);
    ia.MemWrite = 1'b1; ia.Addr = 32'h30; ia.WriteData = 32'h1;
    #1 chk_b("abort_stall", ia.Stall, 1'b1);
    @(negedge clk);
    #1 chk_s("abort_busy", state_a, BUSY);
    drop_a();
    rst = 1'b1;
    #1 chk_s("abort_state", state_a, IDLE);
    chk_b("abort_stall_low", ia.Stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk_b("abort_err", ia.Err, 1'b0);
    chk_w("abort_rdata", ia.ReadData, 32'h0);
    exp_q.push_back(32'hCAFE_0030);
    access(1'b1, 1'b0, 32'h30, 32'h0, 1'b1);

    // Reset in DONE clears the freshly loaded ReadData.
    @(negedge clk);
    ia.MemRead = 1'b1; ia.Addr = 32'h10;
    repeat (LAT_A + 1) @(negedge clk);
    #1 chk_s("done_state", state_a, DONE);
    chk_w("done_rdata", ia.ReadData, 32'hDEAD_BEEF);
    rst = 1'b1;
    #1 chk_w("done_rst_rdata", ia.ReadData, 32'h0);
    chk_s("done_rst_state", state_a, IDLE);
    @(negedge clk);
    drop_a();
    rst = 1'b0;

    // Single-cycle instance.
    @(negedge clk);
    iz.MemWrite = 1'b1; iz.Addr = 32'h40; iz.WriteData = 32'h0000_0077;
    #1 chk_b("z_stall_wr", iz.Stall, 1'b0);
    @(negedge clk);
    iz.MemWrite = 1'b0; iz.MemRead = 1'b1; iz.Addr = 32'h40;
    #1 chk_w("z_rdata", iz.ReadData, 32'h0000_0077);
    chk_b("z_stall_rd", iz.Stall, 1'b0);
    chk_b("z_err_clean", iz.Err, 1'b0);
    @(negedge clk);
    iz.MemRead = 1'b0; iz.MemWrite = 1'b1; iz.Addr = 32'h440; iz.WriteData = 32'h0000_0099;
    @(negedge clk);
    iz.MemWrite = 1'b0; iz.MemRead = 1'b1; iz.Addr = 32'h40;
    #1 chk_w("z_wrap", iz.ReadData, 32'h0000_0099);
    @(negedge clk);
    iz.Addr = 32'h41;
    #1 chk_w("z_misalign_rdata", iz.ReadData, 32'h0000_0099);
    chk_b("z_err_before_edge", iz.Err, 1'b0);
    @(negedge clk);
    iz.MemRead = 1'b0; iz.Addr = 32'h0;
    #1 chk_b("z_err_set", iz.Err, 1'b1);
    chk_b("z_stall_never", iz.Stall, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
